// File: rtl/preproc_sample_packer_if.sv
// AXI-Stream link from the sample packer to the DMA consumer.
interface preproc_sample_packer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/preproc_sample_packer.sv
// Source select, 2x14b -> 32b packer, word FIFO and AXI-Stream output.
module preproc_sample_packer #(
  parameter int ADC_WIDTH  = 14,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_WORDS  = 256,
  parameter logic [ADC_WIDTH-1:0] PATTERN = 14'h2AAA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADC_WIDTH-1:0]  adc_data_i,
  input  logic                  adc_valid_i,
  input  logic                  fifo_en_i,
  input  logic [1:0]            sel_source_i,
  preproc_sample_packer_if.master m,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                  overflow_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(PKT_WORDS);
  localparam int MW = DATA_WIDTH + 1;

  localparam logic [LW-1:0] FULL_L = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WLAST  = CW'(PKT_WORDS - 1);

  localparam logic [1:0] SRC_ADC  = 2'd0;
  localparam logic [1:0] SRC_RAMP = 2'd1;
  localparam logic [1:0] SRC_PAT  = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic                  phase_q, phase_d;
  logic [HW-1:0]         lo_q, lo_d;
  logic [ADC_WIDTH-1:0]  ramp_q, ramp_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [1:0]            src_q, src_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [DATA_WIDTH-1:0] wr_word_q, wr_word_d;
  logic                  wr_last_q, wr_last_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic                  ov_q, ov_d;
  logic [15:0]           drop_q, drop_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  out_lst_q, out_lst_d;

  logic [MW-1:0] mem_q [FIFO_DEPTH];

  logic                 entry, run, take;
  logic                 pop, full, push, drop;
  logic                 pkt_start, avail;
  logic [1:0]           src_cur;
  logic [ADC_WIDTH-1:0] smp;
  logic [HW-1:0]        sx;
  logic [AW-1:0]        rd_nxt, head;
  logic [MW-1:0]        head_w;

  function automatic logic [HW-1:0] sext(
    input logic [ADC_WIDTH-1:0] s
  );
    return {{(HW - ADC_WIDTH){s[ADC_WIDTH-1]}}, s};
  endfunction

  always_comb begin
    state_d = state_q;
    entry   = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_en_i) begin
          state_d = S_RUN;
          entry   = 1'b1;
        end
      end
      S_RUN: begin
        if (!fifo_en_i) state_d = S_IDLE;
        else            run     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign take = run & adc_valid_i;
  assign pop  = out_vld_q & m.m_tready;
  assign full = (cnt_q == FULL_L);
  assign push = wr_pend_q & (~full | pop);
  assign drop = wr_pend_q & full & ~pop;

  // Look through a pending push so a back-to-back sample still sees the boundary
  assign pkt_start = ~phase_q &
    (wr_pend_q ? (wr_last_q & push) : (wcnt_q == '0));
  assign src_cur = pkt_start ? sel_source_i : src_q;

  always_comb begin
    smp = '0;
    unique case (src_cur)
      SRC_ADC:  smp = adc_data_i;
      SRC_RAMP: smp = ramp_q;
      SRC_PAT:  smp = PATTERN;
      default:  smp = '0;
    endcase
  end

  assign sx     = sext(smp);
  assign rd_nxt = rd_ptr_q + AW'(1);
  assign head   = pop ? rd_nxt : rd_ptr_q;
  assign head_w = mem_q[head];
  assign avail  = pop ? (cnt_q > LW'(1)) : (cnt_q != '0);

  always_comb begin
    phase_d   = phase_q;
    lo_d      = lo_q;
    ramp_d    = ramp_q;
    wcnt_d    = wcnt_q;
    src_d     = src_cur;
    wr_pend_d = 1'b0;
    wr_word_d = wr_word_q;
    wr_last_d = wr_last_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ov_d      = ov_q;
    drop_d    = drop_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_lst_d = out_lst_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      wcnt_d   = (wcnt_q == WLAST) ? '0 : wcnt_q + CW'(1);
    end
    if (drop) begin
      ov_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_nxt;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (!out_vld_q || pop) begin
      out_vld_d = avail;
      if (avail) begin
        out_dat_d = head_w[DATA_WIDTH-1:0];
        out_lst_d = head_w[DATA_WIDTH];
      end
    end

    if (take) begin
      if (src_cur == SRC_RAMP) ramp_d = ramp_q + ADC_WIDTH'(1);
      if (!phase_q) begin
        lo_d    = sx;
        phase_d = 1'b1;
      end else begin
        phase_d   = 1'b0;
        wr_pend_d = 1'b1;
        wr_word_d = {sx, lo_q};
        wr_last_d = (wcnt_q == WLAST);
      end
    end

    if (entry) begin
      ramp_d  = '0;
      phase_d = 1'b0;
      wcnt_d  = '0;
      ov_d    = 1'b0;
      drop_d  = '0;
    end
    // Half-filled word is abandoned when capture stops
    if (!fifo_en_i) phase_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_last_q, wr_word_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      lo_q      <= '0;
      ramp_q    <= '0;
      wcnt_q    <= '0;
      src_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_word_q <= '0;
      wr_last_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ov_q      <= 1'b0;
      drop_q    <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_lst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      lo_q      <= lo_d;
      ramp_q    <= ramp_d;
      wcnt_q    <= wcnt_d;
      src_q     <= src_d;
      wr_pend_q <= wr_pend_d;
      wr_word_q <= wr_word_d;
      wr_last_q <= wr_last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ov_q      <= ov_d;
      drop_q    <= drop_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_lst_q <= out_lst_d;
    end
  end

  assign m.m_tdata    = out_dat_q;
  assign m.m_tvalid   = out_vld_q;
  assign m.m_tlast    = out_lst_q;
  assign fifo_level_o = cnt_q;
  assign overflow_o   = ov_q;
  assign drop_cnt_o   = drop_q;

endmodule
